lsu_ctrl: RTL
=============

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16: cycles in REQ without mem_ack before abort.
REQ-002 Parameter ADDR_LIMIT, default 32'h0000_3000: first byte address out of range (12 KiB data space).
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-low (reset==0 at posedge clears state).
REQ-005 req_valid  in  1  CPU-side request present.
REQ-006 req_ready  out  1  block can accept a request (high only in IDLE).
REQ-007 req_we  in  1  1 store, 0 load.
REQ-008 req_op  in  2  access size: 00 word, 01 halfword, 10 byte, 11 treated as word.
REQ-009 req_sign  in  1  loads only: 1 sign-extend, 0 zero-extend.
REQ-010 req_addr, req_wdata, req_pc  in  32 each  byte address, store data, issuing PC.
REQ-011 mem_req  out  1  memory-side request, held until mem_ack or abort.
REQ-012 mem_we  out  1; mem_addr  out  32 (bits [1:0] forced 0); mem_be  out  4; mem_wdata  out  32.
REQ-013 mem_ack  in  1; mem_rdata  in  32  full aligned word, valid in the mem_ack cycle.
REQ-014 rsp_valid  out  1  one-cycle completion pulse; rsp_rdata  out  32; rsp_code  out  2 (00 ok, 01 misaligned, 10 out-of-range, 11 timeout); rsp_pc  out  32.

Function
REQ-015 FSM states IDLE, REQ, RESP; IDLE->REQ on accept (req_valid & req_ready) of a legal request; IDLE->RESP on accept of an illegal request; REQ->RESP on mem_ack or timeout; RESP->IDLE unconditionally.
REQ-016 Accepted request fields are latched at the accept edge; later req_* changes do not affect the transaction.
REQ-017 Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0 -> rsp_code 01, no mem_req issued.
REQ-018 Out-of-range: addr >= ADDR_LIMIT -> rsp_code 10, no mem_req; misalignment takes priority over range.
REQ-019 Latency: accept at edge N -> mem_req high from N+1; mem_ack sampled high at edge M -> rsp_valid high during cycle M+1 only; illegal request -> rsp_valid during cycle N+1.
REQ-020 mem_be: word 1111; halfword addr[1]?1100:0011; byte 0001 shifted left by addr[1:0]; driven for loads and stores.
REQ-021 mem_wdata: word = wdata; halfword = {2{wdata[15:0]}}; byte = {4{wdata[7:0]}}.
REQ-022 mem_we, mem_addr, mem_be, mem_wdata stable for the whole REQ state; all zero outside REQ.
REQ-023 Load data: byte lane per addr[1:0], half lane per addr[1], captured from mem_rdata at the mem_ack edge, extended per req_sign; stores and errors return rsp_rdata = 0.
REQ-024 Timeout counter clears on entering REQ and increments each REQ cycle without mem_ack; at TIMEOUT_CYC cycles mem_req drops and rsp_code 11 is reported.
REQ-025 mem_ack in the same cycle as timeout expiry: ack wins, rsp_code 00.
REQ-026 mem_ack outside REQ is ignored.
REQ-027 No backpressure on response: rsp_valid is never held; earliest next accept is the cycle after RESP (back-to-back throughput one access per 3 cycles at zero wait).
REQ-028 rsp_pc equals the latched req_pc of the completing transaction.

Reset
REQ-029 reset==0 at a posedge: state IDLE, counter 0, all outputs 0 except req_ready=1 from the next cycle.
REQ-030 Reset mid-REQ or mid-RESP abandons the transaction: mem_req and rsp_valid drop on that edge; no response ever issued for it.
REQ-031 Reset has priority over every other input, including simultaneous req_valid and mem_ack.

Verification
REQ-032 Store byte addr 0x0000_0102, wdata 0x1234_56AB, ack after 2 wait cycles -> mem_addr 0x100, mem_be 0100, mem_wdata 0xABABABAB, mem_we 1, rsp_code 00, rsp_rdata 0.
REQ-033 Load half signed addr 0x0000_0206, mem_rdata 0x8001_7FFF -> mem_be 1100, rsp_rdata 0xFFFF_8001; same with req_sign=0 -> 0x0000_8001.
REQ-034 Load word addr 0x0000_0003 -> no mem_req, rsp_valid next cycle, rsp_code 01; load byte addr 0x0000_3000 -> rsp_code 10.
REQ-035 Load word, mem_ack never asserted -> mem_req high exactly 16 cycles then low, rsp_code 11; repeat with ack on 16th cycle -> rsp_code 00.
REQ-036 reset=0 asserted in 2nd REQ cycle with mem_ack next cycle -> mem_req drops, no rsp_valid, req_ready=1 after reset released.
REQ-037 Three back-to-back zero-wait word loads -> rsp_valid every 3rd cycle, rsp_pc matching each req_pc in order.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store controller between the CPU and a word memory.
// Ports: clk, reset (sync, active-low); req_* in, req_ready out; mem_* request/ack; rsp_* completion.
module lsu_ctrl #(
   parameter int          TIMEOUT_CYC = 16,
   parameter logic [31:0] ADDR_LIMIT  = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_op,
   input  logic        req_sign,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_pc,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic [1:0]  rsp_code,
   output logic [31:0] rsp_pc
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

   state_t        r_state, w_next;
   logic [CW-1:0] r_cnt;
   logic          r_we, r_sign;
   logic [1:0]    r_op;
   logic [31:0]   r_addr, r_wdata, r_pc, r_rdata;
   logic [1:0]    r_code;

   logic          w_accept, w_hw, w_b, w_w;
   logic          w_mis, w_oor, w_tmo, w_in_req, w_in_rsp;
   logic          w_lhw, w_lb;
   logic [31:0]   w_sh, w_ld;

   // Size decode of the incoming request (op 11 behaves as word).
   assign w_hw = (req_op == 2'b01);
   assign w_b  = (req_op == 2'b10);
   assign w_w  = ~w_hw & ~w_b;

   assign w_accept = req_valid & (r_state == S_IDLE);
   // Misalignment is checked first and wins over range.
   assign w_mis = (w_hw & req_addr[0]) | (w_w & (|req_addr[1:0]));
   assign w_oor = (req_addr >= ADDR_LIMIT);
   // Last REQ cycle before abort; an ack in this same cycle still wins.
   assign w_tmo = (r_cnt == CW'(TIMEOUT_CYC - 1));

   assign w_in_req = (r_state == S_REQ);
   assign w_in_rsp = (r_state == S_RESP);

   // Load extraction: legal accesses are size-aligned, so a plain
   // right shift by the byte offset selects the byte or half lane.
   assign w_lhw = (r_op == 2'b01);
   assign w_lb  = (r_op == 2'b10);
   assign w_sh  = mem_rdata >> {r_addr[1:0], 3'b000};

   always_comb begin
      w_ld = mem_rdata;
      unique case (1'b1)
         w_lb:    w_ld = {{24{r_sign & w_sh[7]}}, w_sh[7:0]};
         w_lhw:   w_ld = {{16{r_sign & w_sh[15]}}, w_sh[15:0]};
         default: w_ld = mem_rdata;
      endcase
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_accept) w_next = (w_mis | w_oor) ? S_RESP : S_REQ;
         S_REQ:   if (mem_ack | w_tmo) w_next = S_RESP;
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_sign  <= 1'b0;
         r_op    <= 2'b00;
         r_addr  <= '0;
         r_wdata <= '0;
         r_pc    <= '0;
         r_rdata <= '0;
         r_code  <= 2'b00;
      end else begin
         if (w_accept) begin
            r_cnt   <= '0;
            r_we    <= req_we;
            r_sign  <= req_sign;
            r_op    <= req_op;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_pc    <= req_pc;
            r_rdata <= '0;
            r_code  <= w_mis ? 2'b01 : (w_oor ? 2'b10 : 2'b00);
         end else if (w_in_req) begin
            if (mem_ack) begin
               r_code  <= 2'b00;
               r_rdata <= r_we ? 32'h0 : w_ld;
            end else if (w_tmo) begin
               r_code  <= 2'b11;
            end else begin
               r_cnt <= r_cnt + CW'(1);
            end
         end
      end
   end

   always_comb begin
      mem_be    = 4'h0;
      mem_wdata = 32'h0;
      if (w_in_req) begin
         unique case (1'b1)
            w_lb: begin
               mem_be    = 4'b0001 << r_addr[1:0];
               mem_wdata = {4{r_wdata[7:0]}};
            end
            w_lhw: begin
               mem_be    = r_addr[1] ? 4'b1100 : 4'b0011;
               mem_wdata = {2{r_wdata[15:0]}};
            end
            default: begin
               mem_be    = 4'b1111;
               mem_wdata = r_wdata;
            end
         endcase
      end
   end

   assign req_ready = (r_state == S_IDLE);
   assign mem_req   = w_in_req;
   assign mem_we    = w_in_req & r_we;
   assign mem_addr  = w_in_req ? {r_addr[31:2], 2'b00} : 32'h0;
   assign rsp_valid = w_in_rsp;
   assign rsp_rdata = w_in_rsp ? r_rdata : 32'h0;
   assign rsp_code  = w_in_rsp ? r_code : 2'b00;
   assign rsp_pc    = w_in_rsp ? r_pc : 32'h0;

endmodule
